// File: rtl/up_pack_pkg.sv
// up_pack_pkg: shared states, size encodings and byte-mask helper for the phrase packer
package up_pack_pkg;
  typedef enum logic [1:0] {EMPTY, FILL, DRAIN} state_t;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_WORD = 2'd1;
  localparam logic [1:0] SZ_LONG = 2'd2;
  function automatic logic [63:0] be_mask(input logic [7:0] be);
    for (int i = 0; i < 8; i++) be_mask[8*i +: 8] = {8{be[i]}};
  endfunction
endpackage

// File: rtl/up_lane.sv
// up_lane: steers a right-justified narrow write onto big-endian 64-bit phrase lanes
module up_lane
  import up_pack_pkg::*;
(
  input  logic [31:0] in_data,
  input  logic [1:0]  in_size,
  input  logic [2:0]  in_addr,
  output logic [63:0] lane,
  output logic [7:0]  lane_be
);
  logic [2:0] off;
  logic [5:0] sh;
  always_comb begin
    off = in_size == SZ_BYTE ? in_addr : in_size == SZ_WORD ? {in_addr[2:1], 1'b0} : {in_addr[2], 2'b00};
    sh = {off, 3'b000};
    lane = in_size == SZ_BYTE ? {in_data[7:0], 56'd0} >> sh :
           in_size == SZ_WORD ? {in_data[15:0], 48'd0} >> sh : {in_data, 32'd0} >> sh;
    lane_be = in_size == SZ_BYTE ? 8'h80 >> off : in_size == SZ_WORD ? 8'hC0 >> off : 8'hF0 >> off;
  end
endmodule

// File: rtl/up_pack.sv
// up_pack: merges narrow big-endian writes into 64-bit phrases with byte enables
module up_pack
  import up_pack_pkg::*;
#(
  parameter int PA_W = 21
) (
  input  logic            sys_clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_data,
  input  logic [1:0]      in_size,
  input  logic [2:0]      in_addr,
  input  logic [PA_W-1:0] in_phrase,
  input  logic            in_flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [63:0]     out_data,
  output logic [7:0]      out_be,
  output logic [PA_W-1:0] out_phrase
);
  state_t state, nxt_state;
  logic [63:0] lane, mask, nxt_data;
  logic [7:0] lane_be, nxt_be;
  logic [PA_W-1:0] nxt_phrase;
  logic take;
  up_lane u_lane (
    .in_data(in_data),
    .in_size(in_size),
    .in_addr(in_addr),
    .lane(lane),
    .lane_be(lane_be)
  );
  // out_data/out_be double as the accumulator; EMPTY always holds zeros so the merge also loads
  always_comb begin
    mask = be_mask(lane_be);
    out_valid = state == DRAIN;
    in_ready = state == EMPTY || (state == FILL && in_phrase == out_phrase);
    take = in_valid && in_ready;
    nxt_state = state;
    nxt_data = out_data;
    nxt_be = out_be;
    nxt_phrase = out_phrase;
    if (take) begin
      nxt_data = (out_data & ~mask) | (lane & mask);
      nxt_be = out_be | lane_be;
      nxt_phrase = in_phrase;
      nxt_state = (nxt_be == 8'hFF || in_flush) ? DRAIN : FILL;
    end else if (state == FILL && (in_valid || in_flush)) begin
      nxt_state = DRAIN;
    end else if (state == DRAIN && out_ready) begin
      nxt_state = EMPTY;
      nxt_data = '0;
      nxt_be = '0;
    end
  end
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state <= EMPTY;
      out_data <= '0;
      out_be <= '0;
      out_phrase <= '0;
    end else begin
      state <= nxt_state;
      out_data <= nxt_data;
      out_be <= nxt_be;
      out_phrase <= nxt_phrase;
    end
  end
endmodule

// File: doc/up_pack.md
# up_pack

Write-direction phrase packer for the 64-bit DBUS, the counterpart of the 64→32 read-direction downsizer. It accepts narrow big-endian writes (byte, word, long) from a 32-bit master and merges them into one 64-bit phrase with per-byte enables. A phrase is issued to the 64-bit memory side when it is fully written, when a write targets a different phrase, or on an explicit flush.

## Interface
Parameters:
- PA_W, 21, phrase-address width (address bits above bit 2).

Ports:
- sys_clk  in  1  system clock. One clock domain; all logic updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  a narrow write is offered.
- in_ready  out  1  the write is taken this cycle when in_valid & in_ready.
- in_data  in  32  write data, right-justified: byte uses [7:0], word uses [15:0].
- in_size  in  2  write size: 0 = byte, 1 = word, 2 = long, 3 = reserved (treated as long).
- in_addr  in  3  byte offset within the phrase.
- in_phrase  in  PA_W  phrase address.
- in_flush  in  1  force the current partial phrase out.
- out_valid  out  1  a phrase is presented.
- out_ready  in  1  the memory side accepts the phrase.
- out_data  out  64  the phrase data.
- out_be  out  8  byte enables; bit 7 corresponds to out_data[63:56].
- out_phrase  out  PA_W  the phrase address of the presented phrase.

## Operation
- Lane mapping is big-endian:
  - Byte offset k occupies out_data[63-8k -: 8] and out_be[7-k].
  - Word: in_addr[0] is ignored (forced even). Bytes k and k+1 are written, with in_data[15:8] at k.
  - Long: in_addr[1:0] are ignored. Offset 0 maps to [63:32]; offset 4 maps to [31:0].
- States:
  - EMPTY: out_be = 0, out_valid = 0.
  - FILL: accumulating one phrase; the phrase register holds its address.
  - DRAIN: out_valid = 1; outputs are stable until out_ready.
- in_ready is combinational:
  - 1 in EMPTY.
  - In FILL, equals (in_phrase == held phrase).
  - 0 in DRAIN.
- EMPTY:
  - An accepted write loads data, be and phrase, then moves to FILL.
  - If in_flush is also asserted, the block loads and moves straight to DRAIN.
  - in_flush alone does nothing.
- FILL with an accepted write:
  - The write is merged; bytes it enables overwrite earlier data.
  - If the merged be = 8'hFF or in_flush = 1, the next state is DRAIN; otherwise the block stays in FILL.
- FILL without an accepted write:
  - in_valid with a phrase mismatch moves to DRAIN. The write is not taken; it is accepted from EMPTY after the drain.
  - in_flush moves to DRAIN.
- DRAIN with out_ready → EMPTY. out_be and out_data are cleared to 0 on that transition.
- out_data bytes whose out_be bit is 0 are 0. Unenabled lanes are never stale.
- Reset forces EMPTY regardless of state: out_valid = 0, out_data = 0, out_be = 0, out_phrase = 0. Any partial or undelivered phrase is discarded.

## Timing
- Write-to-output latency: out_valid rises on the cycle after the completing or flushing write is accepted.
- Back-to-back writes to one phrase are accepted every cycle.
- A phrase-change write stalls for one DRAIN cycle plus any out_ready wait, then takes one cycle through EMPTY. No write is accepted in the cycle DRAIN exits.
- Sustained throughput with out_ready held high and full long writes:
  - 2 writes per phrase, then 1 drain cycle.
  - This gives 64 bits every 3 cycles.
- out_* are registered outputs. in_ready has a combinational path from in_phrase only.

## Structure
- Package up_pack_pkg holds:
  - The state enum (EMPTY, FILL, DRAIN).
  - Size encodings SZ_BYTE = 2'd0, SZ_WORD = 2'd1, SZ_LONG = 2'd2.
- Sub-module up_lane is combinational. It maps (in_data, in_size, in_addr) to a 64-bit lane-steered value and an 8-bit be.
- The top level holds the FSM and the merge: data = (acc & ~mask) | (lane & mask), where mask is lane_be expanded to bytes.

## Test plan
- Reset, then one byte write of 8'hA5 at phrase 5, offset 3, with in_flush → next cycle out_valid = 1, out_data = 64'h000000A5_00000000, out_be = 8'h10, out_phrase = 5.
- Longs 32'h11223344 at offset 0 then 32'h55667788 at offset 4, both phrase 9 → the phrase issues without a flush: out_data = 64'h1122334455667788, out_be = 8'hFF.
- Word 16'hBEEF at offset 2 in phrase 1, then a byte at phrase 2 → the byte write is stalled and phrase 1 is issued with be = 8'h30. After out_ready, the byte is accepted into a new phrase 2.
- Byte 8'h11 at offset 0, then byte 8'h22 at offset 0, same phrase, then flush → out_data[63:56] = 8'h22 and be = 8'h80, showing overwrite.
- In DRAIN, hold out_ready = 0 for 5 cycles → outputs stay stable and in_ready = 0. Then raise out_ready → EMPTY next cycle.
- Assert reset while in FILL (be = 8'h0F) → next cycle out_be = 0 and out_valid = 0. A subsequent flush produces no output.
